id_hazard_unit: RTL and testbench

- Decode-stage hazard and forwarding controller. It sits directly upstream of the register file read ports in the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers for EX, MEM and WB in a 3-slot shift register. Drives the register file read enables and per-operand forward selects, and raises load-use and divider-busy stalls.
- Results written back in WB reach ID through the register file's own write-through path, so the WB slot always selects the register file.

---
 rtl/id_hazard_unit.sv | 104 ++++++++++
 tb/tb_id_hazard_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_unit.sv
// Decode-stage hazard and forwarding controller: tracks in-flight destinations
// for EX/MEM/WB, drives register file read enables, forward selects and stalls.
module id_hazard_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_id_valid,
  input  logic [4:0] in_id_rs_addr,
  input  logic [4:0] in_id_rt_addr,
  input  logic       in_id_rs_use,
  input  logic       in_id_rt_use,
  input  logic [4:0] in_id_rd_addr,
  input  logic       in_id_rd_wena,
  input  logic       in_id_is_load,
  input  logic       in_id_is_div,
  input  logic       in_id_uses_hilo,
  input  logic       in_flush,
  output logic       out_stall,
  output logic       out_rs_ena,
  output logic       out_rt_ena,
  output logic [1:0] out_rs_fwd,
  output logic [1:0] out_rt_fwd,
  output logic       out_div_busy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

  slot_t      ex_q, mem_q, wb_q;
  logic [5:0] div_cnt_q;

  logic       div_busy_raw;
  logic       load_use;
  logic       div_stall;
  logic       stall;
  logic       issue;
  logic [1:0] rs_sel, rt_sel;

  // Register 0 is hardwired, so it never matches an in-flight producer.
  function automatic logic slot_match(input slot_t s, input logic [4:0] a);
    return s.valid && (s.rd == a) && (a != 5'd0);
  endfunction

  // WB results reach ID through the register file write-through path.
  function automatic logic [1:0] fwd_sel(input logic [4:0] a);
    logic [1:0] sel;
    sel = FWD_RF;
    if (slot_match(ex_q, a) && !ex_q.is_load) sel = FWD_EX;
    else if (slot_match(mem_q, a))            sel = FWD_MEM;
    else if (slot_match(wb_q, a))             sel = FWD_RF;
    return sel;
  endfunction

  // Handshake: in_id_valid marks a real instruction in ID; it is accepted
  // (issued into EX) on an edge where out_stall and in_flush are both low.
  assign div_busy_raw = (div_cnt_q != 6'd0);
  assign load_use = in_id_valid && ex_q.is_load &&
                    ((in_id_rs_use && slot_match(ex_q, in_id_rs_addr)) ||
                     (in_id_rt_use && slot_match(ex_q, in_id_rt_addr)));
  assign div_stall = in_id_valid && div_busy_raw && (in_id_is_div || in_id_uses_hilo);
  assign stall     = (load_use || div_stall) && !in_flush && !in_rst;
  assign issue     = in_id_valid && !stall && !in_flush;

  assign rs_sel = fwd_sel(in_id_rs_addr);
  assign rt_sel = fwd_sel(in_id_rt_addr);

  assign out_stall    = stall;
  assign out_rs_ena   = in_id_valid && in_id_rs_use && !in_rst;
  assign out_rt_ena   = in_id_valid && in_id_rt_use && !in_rst;
  assign out_rs_fwd   = in_rst ? FWD_RF : rs_sel;
  assign out_rt_fwd   = in_rst ? FWD_RF : rt_sel;
  assign out_div_busy = div_busy_raw && !in_rst;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      div_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (issue) begin
        ex_q.valid   <= in_id_rd_wena && (in_id_rd_addr != 5'd0);
        ex_q.rd      <= in_id_rd_addr;
        ex_q.is_load <= in_id_is_load;
      end else begin
        ex_q.valid <= 1'b0;
      end
      if (issue && in_id_is_div) div_cnt_q <= DIV_LOAD;
      else if (div_busy_raw)     div_cnt_q <= div_cnt_q - 6'd1;
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Bench for id_hazard_unit: reference model feeds an expected queue checked
// each cycle, plus directed scenario checks with hand-derived values.
module tb_id_hazard_unit;

  localparam int DIV_CYCLES = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic [4:0] rd;
    logic       wena;
    logic       ld;
    logic       dv;
    logic       hl;
  } instr_t;

  logic       in_clk;
  logic       in_rst;
  logic       in_id_valid;
  logic [4:0] in_id_rs_addr;
  logic [4:0] in_id_rt_addr;
  logic       in_id_rs_use;
  logic       in_id_rt_use;
  logic [4:0] in_id_rd_addr;
  logic       in_id_rd_wena;
  logic       in_id_is_load;
  logic       in_id_is_div;
  logic       in_id_uses_hilo;
  logic       in_flush;
  logic       out_stall;
  logic       out_rs_ena;
  logic       out_rt_ena;
  logic [1:0] out_rs_fwd;
  logic [1:0] out_rt_fwd;
  logic       out_div_busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  // reference model state
  logic       m_v[3];
  logic [4:0] m_rd[3];
  logic       m_ld[3];
  int         m_cnt;

  id_hazard_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_id_valid(in_id_valid),
    .in_id_rs_addr(in_id_rs_addr), .in_id_rt_addr(in_id_rt_addr),
    .in_id_rs_use(in_id_rs_use), .in_id_rt_use(in_id_rt_use),
    .in_id_rd_addr(in_id_rd_addr), .in_id_rd_wena(in_id_rd_wena),
    .in_id_is_load(in_id_is_load), .in_id_is_div(in_id_is_div),
    .in_id_uses_hilo(in_id_uses_hilo), .in_flush(in_flush),
    .out_stall(out_stall), .out_rs_ena(out_rs_ena), .out_rt_ena(out_rt_ena),
    .out_rs_fwd(out_rs_fwd), .out_rt_fwd(out_rt_fwd), .out_div_busy(out_div_busy)
  );

  // clock / reset
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  function automatic logic m_match(input int s, input logic [4:0] a);
    return m_v[s] && (m_rd[s] == a) && (a != 5'd0);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] a);
    if (m_match(0, a) && !m_ld[0]) return 2'd1;
    if (m_match(1, a)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    logic lu, ds;
    lu = in_id_valid && m_ld[0] &&
         ((in_id_rs_use && m_match(0, in_id_rs_addr)) ||
          (in_id_rt_use && m_match(0, in_id_rt_addr)));
    ds = in_id_valid && (m_cnt != 0) && (in_id_is_div || in_id_uses_hilo);
    return (lu || ds) && !in_flush && !in_rst;
  endfunction

  function automatic logic [7:0] m_expected();
    if (in_rst) return 8'h00;
    return {m_stall(), in_id_valid && in_id_rs_use, in_id_valid && in_id_rt_use,
            m_fwd(in_id_rs_addr), m_fwd(in_id_rt_addr), m_cnt != 0};
  endfunction

  task automatic model_edge();
    logic iss;
    if (in_rst) begin
      for (int s = 0; s < 3; s++) begin
        m_v[s] = 1'b0; m_rd[s] = 5'd0; m_ld[s] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      iss = in_id_valid && !m_stall() && !in_flush;
      for (int s = 2; s > 0; s--) begin
        m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_ld[s] = m_ld[s-1];
      end
      m_v[0] = iss && in_id_rd_wena && (in_id_rd_addr != 5'd0);
      m_rd[0] = in_id_rd_addr;
      m_ld[0] = in_id_is_load;
      if (iss && in_id_is_div) m_cnt = DIV_CYCLES;
      else if (m_cnt != 0)     m_cnt = m_cnt - 1;
    end
  endtask

  // driver: advance one edge, then present the next ID contents
  task automatic cycle(input instr_t i, input logic fl, input logic rst);
    @(posedge in_clk);
    model_edge();
    #1;
    in_id_valid = i.v;    in_id_rs_addr = i.rs; in_id_rt_addr = i.rt;
    in_id_rs_use = i.rsu; in_id_rt_use = i.rtu; in_id_rd_addr = i.rd;
    in_id_rd_wena = i.wena; in_id_is_load = i.ld; in_id_is_div = i.dv;
    in_id_uses_hilo = i.hl; in_flush = fl; in_rst = rst;
    exp_q.push_back(m_expected());
    #1;
  endtask

  // scoreboard monitor: compares on the falling edge
  always @(negedge in_clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e, a;
      e = exp_q.pop_front();
      a = {out_stall, out_rs_ena, out_rt_ena, out_rs_fwd, out_rt_fwd, out_div_busy};
      n_checks++;
      if (a !== e) $display("FAIL scoreboard t=%0t got=%b exp=%b", $time, a, e);
      else n_pass++;
    end
  end

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.v = 1'b1; i.rs = rs; i.rt = rt; i.rsu = 1'b1; i.rtu = 1'b1; i.rd = rd; i.wena = 1'b1;
    return i;
  endfunction

  function automatic instr_t load(input logic [4:0] rd, input logic [4:0] base);
    instr_t i = '0;
    i.v = 1'b1; i.rs = base; i.rt = rd; i.rsu = 1'b1; i.rd = rd; i.wena = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t div_i(input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = alu(5'd0, rs, rt);
    i.wena = 1'b0; i.dv = 1'b1;
    return i;
  endfunction

  function automatic instr_t mfhi_i(input logic [4:0] rd);
    instr_t i = '0;
    i.v = 1'b1; i.rd = rd; i.wena = 1'b1; i.hl = 1'b1;
    return i;
  endfunction

  task automatic drain();
    for (int k = 0; k < 4; k++) cycle(nop(), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1);
    cycle(div_i(5'd1, 5'd2), 1'b0, 1'b1);
    n_checks++;
    if ({out_stall, out_rs_ena, out_rt_ena, out_rs_fwd, out_rt_fwd, out_div_busy} !== 8'h00)
      $display("FAIL reset_outputs got=%b exp=00000000",
               {out_stall, out_rs_ena, out_rt_ena, out_rs_fwd, out_rt_fwd, out_div_busy});
    else n_pass++;
    cycle(alu(5'd4, 5'd3, 5'd3), 1'b0, 1'b0);
    n_checks++;
    if (out_rs_fwd !== 2'd0 || out_div_busy !== 1'b0 || out_rs_ena !== 1'b1)
      $display("FAIL after_reset got=%0d/%b/%b exp=0/0/1", out_rs_fwd, out_div_busy, out_rs_ena);
    else n_pass++;
    drain();
  endtask

  task automatic test_forward();
    cycle(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
    cycle(alu(5'd4, 5'd3, 5'd5), 1'b0, 1'b0);
    n_checks++;
    if (out_rs_fwd !== 2'd1 || out_rt_fwd !== 2'd0 || out_stall !== 1'b0)
      $display("FAIL fwd_ex got=%0d/%0d/%b exp=1/0/0", out_rs_fwd, out_rt_fwd, out_stall);
    else n_pass++;
    cycle(alu(5'd6, 5'd3, 5'd0), 1'b0, 1'b0);
    n_checks++;
    if (out_rs_fwd !== 2'd2 || out_rt_fwd !== 2'd0)
      $display("FAIL fwd_mem got=%0d/%0d exp=2/0", out_rs_fwd, out_rt_fwd);
    else n_pass++;
    drain();
  endtask

  task automatic test_load_use();
    cycle(load(5'd8, 5'd9), 1'b0, 1'b0);
    cycle(alu(5'd10, 5'd8, 5'd8), 1'b0, 1'b0);
    n_checks++;
    if (out_stall !== 1'b1) $display("FAIL load_use_stall got=%b exp=1", out_stall);
    else n_pass++;
    cycle(alu(5'd10, 5'd8, 5'd8), 1'b0, 1'b0);
    n_checks++;
    if (out_stall !== 1'b0 || out_rs_fwd !== 2'd2 || out_rt_fwd !== 2'd2)
      $display("FAIL load_use_resolve got=%b/%0d/%0d exp=0/2/2", out_stall, out_rs_fwd, out_rt_fwd);
    else n_pass++;
    // the EX slot was a bubble during the stall, so $10 arrives one cycle later
    cycle(alu(5'd11, 5'd10, 5'd8), 1'b0, 1'b0);
    n_checks++;
    if (out_rs_fwd !== 2'd1 || out_rt_fwd !== 2'd0)
      $display("FAIL after_stall got=%0d/%0d exp=1/0", out_rs_fwd, out_rt_fwd);
    else n_pass++;
    drain();
  endtask

  task automatic test_zero_reg();
    cycle(load(5'd0, 5'd9), 1'b0, 1'b0);
    cycle(alu(5'd12, 5'd0, 5'd0), 1'b0, 1'b0);
    n_checks++;
    if (out_stall !== 1'b0 || out_rs_fwd !== 2'd0 || out_rt_fwd !== 2'd0)
      $display("FAIL zero_reg got=%b/%0d/%0d exp=0/0/0", out_stall, out_rs_fwd, out_rt_fwd);
    else n_pass++;
    drain();
    cycle(alu(5'd7, 5'd1, 5'd2), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      instr_t rd7;
      logic [1:0] want;
      rd7 = alu(5'd0, 5'd7, 5'd1);
      rd7.wena = 1'b0;
      want = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
      cycle(rd7, 1'b0, 1'b0);
      n_checks++;
      if (out_rs_fwd !== want) $display("FAIL advance_%0d got=%0d exp=%0d", k, out_rs_fwd, want);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_div();
    cycle(div_i(5'd1, 5'd2), 1'b0, 1'b0);
    for (int k = 1; k <= DIV_CYCLES; k++) begin
      cycle(mfhi_i(5'd12), 1'b0, 1'b0);
      n_checks++;
      if (out_stall !== 1'b1 || out_div_busy !== 1'b1)
        $display("FAIL div_busy_t%0d got=%b/%b exp=1/1", k, out_stall, out_div_busy);
      else n_pass++;
    end
    cycle(mfhi_i(5'd12), 1'b0, 1'b0);
    n_checks++;
    if (out_stall !== 1'b0 || out_div_busy !== 1'b0)
      $display("FAIL div_done got=%b/%b exp=0/0", out_stall, out_div_busy);
    else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    instr_t cons;
    cycle(load(5'd8, 5'd9), 1'b0, 1'b0);
    cons = alu(5'd11, 5'd8, 5'd8);
    cons.dv = 1'b1;
    cycle(cons, 1'b1, 1'b0);
    n_checks++;
    if (out_stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", out_stall);
    else n_pass++;
    cycle(alu(5'd13, 5'd11, 5'd8), 1'b0, 1'b0);
    n_checks++;
    if (out_rs_fwd !== 2'd0 || out_rt_fwd !== 2'd2 || out_div_busy !== 1'b0)
      $display("FAIL flush_bubble got=%0d/%0d/%b exp=0/2/0", out_rs_fwd, out_rt_fwd, out_div_busy);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    instr_t rd13;
    cycle(div_i(5'd1, 5'd2), 1'b0, 1'b0);
    cycle(load(5'd13, 5'd9), 1'b0, 1'b0);
    rd13 = mfhi_i(5'd14);
    rd13.rs = 5'd13; rd13.rsu = 1'b1;
    cycle(rd13, 1'b0, 1'b1);
    n_checks++;
    if (out_stall !== 1'b0 || out_div_busy !== 1'b0 || out_rs_fwd !== 2'd0)
      $display("FAIL in_reset got=%b/%b/%0d exp=0/0/0", out_stall, out_div_busy, out_rs_fwd);
    else n_pass++;
    cycle(rd13, 1'b0, 1'b0);
    n_checks++;
    if (out_stall !== 1'b0 || out_div_busy !== 1'b0 || out_rs_fwd !== 2'd0)
      $display("FAIL post_reset got=%b/%b/%0d exp=0/0/0", out_stall, out_div_busy, out_rs_fwd);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      instr_t i;
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0: i = nop();
        1: i = load(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        2: i = div_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        3: i = mfhi_i(5'($urandom_range(0, 7)));
        default: i = alu(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)));
      endcase
      i.rsu = i.rsu & ($urandom_range(0, 3) != 0);
      cycle(i, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end
    drain();
  endtask

  initial begin
    in_rst = 1'b1; in_id_valid = 1'b0; in_id_rs_addr = '0; in_id_rt_addr = '0;
    in_id_rs_use = 1'b0; in_id_rt_use = 1'b0; in_id_rd_addr = '0; in_id_rd_wena = 1'b0;
    in_id_is_load = 1'b0; in_id_is_div = 1'b0; in_id_uses_hilo = 1'b0; in_flush = 1'b0;
    m_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 1'b0; m_rd[s] = 5'd0; m_ld[s] = 1'b0;
    end
    test_reset();
    test_forward();
    test_load_use();
    test_zero_reg();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    @(negedge in_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
